// File: rtl/apb_i2c_fifo.sv
// apb_i2c_fifo
// Synchronous first-word-fall-through FIFO used on both the TX and RX sides
// of the APB I2C bridge. The head word is presented combinationally on
// RD_DATA so the APB slave can return it in the same cycle that pops it.
//
// Strobe semantics (applies to both sides): WR_EN and RD_EN are level
// strobes sampled on every rising PCLK edge; each high cycle is one push or
// pop attempt. A push is accepted when the FIFO is not full, or when it is
// full and a pop happens in the same cycle. A pop is accepted whenever the
// FIFO is not empty. Rejected attempts leave storage and pointers untouched
// and set the matching sticky error flag instead.
module apb_i2c_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic                        WR_EN,
    input  logic [DWIDTH-1:0]           WR_DATA,
    input  logic                        RD_EN,
    output logic [DWIDTH-1:0]           RD_DATA,
    output logic                        FULL,
    output logic                        EMPTY,
    output logic                        ALMOST_FULL,
    output logic [$clog2(DEPTH):0]      COUNT,
    output logic                        OVERFLOW,
    output logic                        UNDERFLOW,
    input  logic                        ERR_CLR
);

    // Pointer width follows the depth; it is not meant to be overridden.
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] DEPTH_CNT    = (AW+1)'(DEPTH);
    localparam logic [AW:0] ALMOST_LEVEL = (AW+1)'(DEPTH - 1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic [AW:0]       count_q;
    logic              overflow_q;
    logic              underflow_q;

    logic              full_w;
    logic              empty_w;
    logic              push_ok;
    logic              pop_ok;
    logic              ovf_evt;
    logic              unf_evt;

    // Status decoded from the registered count only, never from the strobes.
    always_comb begin
        full_w      = (count_q == DEPTH_CNT);
        empty_w     = (count_q == '0);
        FULL        = full_w;
        EMPTY       = empty_w;
        ALMOST_FULL = (count_q >= ALMOST_LEVEL);
        COUNT       = count_q;
        OVERFLOW    = overflow_q;
        UNDERFLOW   = underflow_q;
    end

    // Accept/reject decisions for this cycle's strobes.
    always_comb begin
        // A pop while full frees a slot in the same edge, so the push may proceed.
        push_ok = WR_EN && (!full_w || RD_EN);
        pop_ok  = RD_EN && !empty_w;
        ovf_evt = WR_EN && full_w && !RD_EN;
        // On an empty FIFO the pop is rejected even if a push lands this edge.
        unf_evt = RD_EN && empty_w;
    end

    // Storage write; contents are never reset, and the reset cycle writes nothing.
    always_ff @(posedge PCLK) begin
        if (!PRESET && push_ok) begin
            mem[wp] <= WR_DATA;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wp      <= '0;
            rp      <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wp <= wp + 1'b1;
            end
            if (pop_ok) begin
                rp <= rp + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Sticky error flags; a new event in the clearing cycle wins over the clear.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= ovf_evt || (overflow_q  && !ERR_CLR);
            underflow_q <= unf_evt || (underflow_q && !ERR_CLR);
        end
    end

    // First-word-fall-through head; forced to zero when nothing is stored.
    always_comb begin
        RD_DATA = '0;
        if (!empty_w) begin
            RD_DATA = mem[rp];
        end
    end

endmodule

// File: tb/tb_apb_i2c_fifo.sv
// Directed bench for apb_i2c_fifo: reset, fill, overflow, drain, underflow,
// flag clear, simultaneous strobes at empty and full, wrap-around streaming
// and a mid-stream reset. Expected values are hand-computed constants.
module tb_apb_i2c_fifo;

    localparam int DWIDTH = 32;
    localparam int DEPTH  = 16;

    logic              PCLK;
    logic              PRESET;
    logic              WR_EN;
    logic [DWIDTH-1:0] WR_DATA;
    logic              RD_EN;
    logic [DWIDTH-1:0] RD_DATA;
    logic              FULL;
    logic              EMPTY;
    logic              ALMOST_FULL;
    logic [4:0]        COUNT;
    logic              OVERFLOW;
    logic              UNDERFLOW;
    logic              ERR_CLR;

    int total;
    int bad;

    apb_i2c_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .WR_EN       (WR_EN),
        .WR_DATA     (WR_DATA),
        .RD_EN       (RD_EN),
        .RD_DATA     (RD_DATA),
        .FULL        (FULL),
        .EMPTY       (EMPTY),
        .ALMOST_FULL (ALMOST_FULL),
        .COUNT       (COUNT),
        .OVERFLOW    (OVERFLOW),
        .UNDERFLOW   (UNDERFLOW),
        .ERR_CLR     (ERR_CLR)
    );

    // clock
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // one rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        WR_EN   = 1'b0;
        RD_EN   = 1'b0;
        ERR_CLR = 1'b0;
        WR_DATA = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        PRESET = 1'b1;

        // ---- reset state
        step();
        check("rst_count",  32'(COUNT), 32'd0);
        check("rst_empty",  32'(EMPTY), 32'd1);
        check("rst_full",   32'(FULL), 32'd0);
        check("rst_af",     32'(ALMOST_FULL), 32'd0);
        check("rst_ovf",    32'(OVERFLOW), 32'd0);
        check("rst_unf",    32'(UNDERFLOW), 32'd0);
        check("rst_rdata",  RD_DATA, 32'h0);
        PRESET = 1'b0;

        // ---- fill with 0x1000+i
        for (int i = 0; i < 16; i++) begin
            WR_EN   = 1'b1;
            WR_DATA = 32'h1000 + 32'(i);
            step();
            check("fill_count", 32'(COUNT), 32'(i + 1));
            check("fill_rdata", RD_DATA, 32'h1000);
            check("fill_af",    32'(ALMOST_FULL), (i + 1 >= 15) ? 32'd1 : 32'd0);
            check("fill_full",  32'(FULL), (i + 1 == 16) ? 32'd1 : 32'd0);
            check("fill_empty", 32'(EMPTY), 32'd0);
        end

        // ---- overflow: push without pop while full
        WR_DATA = 32'hDEAD;
        step();
        WR_EN = 1'b0;
        check("ovf_flag",  32'(OVERFLOW), 32'd1);
        check("ovf_count", 32'(COUNT), 32'd16);
        check("ovf_head",  RD_DATA, 32'h1000);
        check("ovf_unf",   32'(UNDERFLOW), 32'd0);

        // ---- drain 16 words in order
        for (int i = 0; i < 16; i++) begin
            check("drain_data", RD_DATA, 32'h1000 + 32'(i));
            RD_EN = 1'b1;
            step();
            check("drain_count", 32'(COUNT), 32'(15 - i));
        end
        RD_EN = 1'b0;
        check("drain_empty", 32'(EMPTY), 32'd1);
        check("drain_rdata", RD_DATA, 32'h0);
        check("drain_unf",   32'(UNDERFLOW), 32'd0);

        // ---- underflow on empty pop
        RD_EN = 1'b1;
        step();
        RD_EN = 1'b0;
        check("unf_flag",  32'(UNDERFLOW), 32'd1);
        check("unf_count", 32'(COUNT), 32'd0);
        check("unf_ovf",   32'(OVERFLOW), 32'd1);

        // ---- clear both flags
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        check("clr_ovf", 32'(OVERFLOW), 32'd0);
        check("clr_unf", 32'(UNDERFLOW), 32'd0);

        // ---- set wins over clear in the same cycle
        ERR_CLR = 1'b1;
        RD_EN   = 1'b1;
        step();
        clear_inputs();
        check("setwin_unf", 32'(UNDERFLOW), 32'd1);
        check("setwin_ovf", 32'(OVERFLOW), 32'd0);
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        check("clr2_unf", 32'(UNDERFLOW), 32'd0);

        // ---- simultaneous push and pop while empty
        WR_EN   = 1'b1;
        WR_DATA = 32'hA5A5A5A5;
        RD_EN   = 1'b1;
        step();
        clear_inputs();
        check("se_unf",   32'(UNDERFLOW), 32'd1);
        check("se_count", 32'(COUNT), 32'd1);
        check("se_rdata", RD_DATA, 32'hA5A5A5A5);
        check("se_empty", 32'(EMPTY), 32'd0);

        // ---- wrap-around streaming from a fresh reset
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            WR_EN   = 1'b1;
            WR_DATA = 32'h2000 + 32'(i);
            step();
        end
        check("pre_count", 32'(COUNT), 32'd8);
        for (int k = 0; k < 40; k++) begin
            check("stream_data", RD_DATA, 32'h2000 + 32'(k));
            WR_EN   = 1'b1;
            WR_DATA = 32'h2008 + 32'(k);
            RD_EN   = 1'b1;
            step();
            check("stream_count", 32'(COUNT), 32'd8);
        end
        clear_inputs();
        check("stream_ovf", 32'(OVERFLOW), 32'd0);
        check("stream_unf", 32'(UNDERFLOW), 32'd0);
        check("stream_head", RD_DATA, 32'h2028);

        // ---- fill to full, then push and pop together while full
        for (int i = 0; i < 8; i++) begin
            WR_EN   = 1'b1;
            WR_DATA = 32'h2030 + 32'(i);
            step();
        end
        WR_EN = 1'b0;
        check("full2_full",  32'(FULL), 32'd1);
        check("full2_count", 32'(COUNT), 32'd16);
        WR_EN   = 1'b1;
        WR_DATA = 32'h3000;
        RD_EN   = 1'b1;
        step();
        clear_inputs();
        check("sf_count", 32'(COUNT), 32'd16);
        check("sf_ovf",   32'(OVERFLOW), 32'd0);
        check("sf_head",  RD_DATA, 32'h2029);

        // ---- mid-stream reset with 5 words held and both strobes high
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            WR_EN   = 1'b1;
            WR_DATA = 32'h4000 + 32'(i);
            step();
        end
        check("ms_pre_count", 32'(COUNT), 32'd5);
        PRESET  = 1'b1;
        WR_EN   = 1'b1;
        WR_DATA = 32'h5555;
        RD_EN   = 1'b1;
        step();
        clear_inputs();
        PRESET = 1'b0;
        check("ms_count", 32'(COUNT), 32'd0);
        check("ms_empty", 32'(EMPTY), 32'd1);
        check("ms_rdata", RD_DATA, 32'h0);
        WR_EN   = 1'b1;
        WR_DATA = 32'h77;
        step();
        clear_inputs();
        check("ms_push_data",  RD_DATA, 32'h77);
        check("ms_push_count", 32'(COUNT), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_i2c_fifo.md
# apb_i2c_fifo

Synchronous first-word-fall-through FIFO buffering 32-bit words between the APB slave interface and the I2C core. Two instances are used: the TX instance is written by the APB write strobe (`WR_ENA`) and drained by the I2C core; the RX instance is filled by the I2C core and popped by the APB read strobe (`RD_ENA`). The RX instance drives the APB read data directly. Its empty/full and error outputs feed the interrupt lines (`TX_EMPTY`, `RX_EMPTY`) and the `ERROR` input of the APB slave.

## Interface
- `DWIDTH`, 32: word width in bits.
- `DEPTH`, 16: number of entries; power of two, at least 4.
- `AW`, log2(`DEPTH`): pointer width; derived, not overridden.
- `PCLK` input 1: single clock; all state updates on its rising edge.
- `PRESET` input 1: reset, synchronous, active-high.
- `WR_EN` input 1: push strobe, one word per cycle while high.
- `WR_DATA` input `DWIDTH`: word pushed when `WR_EN` is accepted.
- `RD_EN` input 1: pop strobe, one word per cycle while high.
- `RD_DATA` output `DWIDTH`: head word (first-word-fall-through); all zeros when `EMPTY`.
- `FULL` output 1: count == `DEPTH`.
- `EMPTY` output 1: count == 0.
- `ALMOST_FULL` output 1: count >= `DEPTH`-1.
- `COUNT` output `AW`+1: current occupancy, 0..`DEPTH`.
- `OVERFLOW` output 1: sticky; set by a rejected push.
- `UNDERFLOW` output 1: sticky; set by a rejected pop.
- `ERR_CLR` input 1: clears both sticky flags.

## Operation
- **Storage.** `DEPTH` x `DWIDTH` register array. Write pointer `wp` and read pointer `rp` are `AW` bits wide and wrap modulo `DEPTH`. Storage contents are not reset.
- **Push accepted** when `WR_EN` && (!`FULL` || `RD_EN`). Then `mem[wp]` <= `WR_DATA` and `wp` <= `wp`+1.
- **Pop accepted** when `RD_EN` && !`EMPTY`. Then `rp` <= `rp`+1.
- **Count update.** `COUNT` increments on a push alone, decrements on a pop alone, and is unchanged when both are accepted.
- **Simultaneous push and pop while `FULL`.** Both are accepted; `COUNT` stays at `DEPTH`; no overflow.
- **Simultaneous push and pop while `EMPTY`.** The push is accepted and the pop is rejected. `UNDERFLOW` is set. Next cycle `COUNT` = 1 and `RD_DATA` = the pushed word.
- **Rejected push.** `WR_EN` while `FULL` && !`RD_EN`: contents and pointers unchanged; `OVERFLOW` <= 1.
- **Rejected pop.** `RD_EN` while `EMPTY`: pointers unchanged; `UNDERFLOW` <= 1.
- **Sticky flags.** `ERR_CLR` clears both flags. If `ERR_CLR` and a new error event occur in the same cycle, the set wins.
- **Status outputs.** `FULL`, `EMPTY`, `ALMOST_FULL` and `COUNT` are registered, or decoded from the registered count only. They never depend combinationally on `WR_EN` or `RD_EN`.
- **Read data.** `RD_DATA` = `EMPTY` ? 0 : `mem[rp]`, as a combinational read of registered state. This lets the APB slave return the head word in the same access-phase cycle that asserts `RD_ENA`.

## Timing
- **Reset.** `PRESET` high at a `PCLK` edge gives, at that edge: `wp` = `rp` = 0, `COUNT` = 0, `EMPTY` = 1, `FULL` = 0, `ALMOST_FULL` = 0, `OVERFLOW` = `UNDERFLOW` = 0, `RD_DATA` = 0.
- **Reset mid-operation.** Reset discards all contents, and strobes in the reset cycle are ignored.
- **Push latency.** A word pushed at edge N is visible on `RD_DATA` after edge N if the FIFO was empty. `EMPTY` falls after edge N.
- **Pop latency.** A pop at edge N presents the next word, or zero if none, after edge N.
- **Throughput.** One push and one pop per cycle, sustained, with no bubbles.
- **Status timing.** All status outputs reflect the state after the most recent edge.

## Test plan
- **Reset, then fill.** Reset, then 16 consecutive pushes of 0x1000+i -> `COUNT` 1..16, `ALMOST_FULL` at 15, `FULL` after the 16th push, `RD_DATA` = 0x1000 throughout.
- **Overflow.** With the FIFO full, push 0xDEAD with no pop -> `OVERFLOW` = 1, `COUNT` stays 16. Then drain 16 words -> values 0x1000..0x100F in order, then `EMPTY` = 1 and `RD_DATA` = 0.
- **Underflow, pop and clear.** Pop when empty -> `UNDERFLOW` = 1, `COUNT` 0. Pulse `ERR_CLR` -> both flags 0.
- **Simultaneous strobes when empty.** Push 0xA5A5A5A5 and pop together while empty -> `UNDERFLOW` = 1, `COUNT` = 1, `RD_DATA` = 0xA5A5A5A5.
- **Wrap-around streaming.** Push 8 words, then 40 cycles of simultaneous push and pop with an incrementing pattern -> `COUNT` stays at 8, output order is preserved across the pointer wrap, and there are no errors.
- **Mid-stream reset.** Assert `PRESET` for one cycle while holding 5 words and with both strobes high -> `COUNT` = 0 and `EMPTY` = 1. The next push of 0x77 reads back as 0x77.
